// File: rtl/obi_cmd_manager.sv
// OBI manager: turns a valid/ready command stream into single OBI transactions
// and returns each result on a valid/ready response stream.
// Optional feature macro: OBI_CMD_MGR_TIMEOUT_EN (WAIT_R timeout plus stale-rvalid drop).

package obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

  localparam int unsigned DefAddrWidth = ObiDefaultConfig.AddrWidth;
  localparam int unsigned DefDataWidth = ObiDefaultConfig.DataWidth;
  localparam int unsigned DefIdWidth   = ObiDefaultConfig.IdWidth;

  // A channel payload
  typedef struct packed {
    logic [DefAddrWidth-1:0]   addr;
    logic                      we;
    logic [DefDataWidth/8-1:0] be;
    logic [DefDataWidth-1:0]   wdata;
    logic [DefIdWidth-1:0]     aid;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
  } obi_req_t;

  // R channel payload
  typedef struct packed {
    logic [DefDataWidth-1:0] rdata;
    logic [DefIdWidth-1:0]   rid;
    logic                    err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

module obi_cmd_manager #(
  parameter obi_pkg::obi_cfg_t ObiCfg        = obi_pkg::ObiDefaultConfig,
  parameter type               obi_req_t     = obi_pkg::obi_req_t,
  parameter type               obi_rsp_t     = obi_pkg::obi_rsp_t,
  parameter int unsigned       TimeoutCycles = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic [ObiCfg.AddrWidth-1:0]     cmd_addr_i,
  input  logic                            cmd_we_i,
  input  logic [ObiCfg.DataWidth/8-1:0]   cmd_be_i,
  input  logic [ObiCfg.DataWidth-1:0]     cmd_wdata_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [ObiCfg.DataWidth-1:0]     rsp_rdata_o,
  output logic                            rsp_err_o,
  output obi_req_t                        obi_req_o,
  input  obi_rsp_t                        obi_rsp_i
);

  localparam int unsigned AddrWidth = ObiCfg.AddrWidth;
  localparam int unsigned DataWidth = ObiCfg.DataWidth;
  localparam int unsigned BeWidth   = DataWidth / 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] WAIT_R = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  // Reject configurations that would make the timeout counter degenerate
  if (TimeoutCycles < 2) begin : g_bad_timeout
    $error("obi_cmd_manager: TimeoutCycles must be >= 2");
  end

  logic [1:0]           state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [BeWidth-1:0]   be_q, be_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 req_q, req_d;

`ifdef OBI_CMD_MGR_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                stale_q, stale_d;
`endif

  // The response ID is not tracked: only one transaction is ever in flight
  logic unused_rid;
  assign unused_rid = ^obi_rsp_i.r.rid;

  // Next-state, datapath capture and next output values
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef OBI_CMD_MGR_TIMEOUT_EN
    cnt_d   = cnt_q;
    stale_d = stale_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          addr_d  = cmd_addr_i;
          we_d    = cmd_we_i;
          be_d    = cmd_be_i;
          wdata_d = cmd_we_i ? cmd_wdata_i : '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (obi_rsp_i.gnt) begin
          state_d = WAIT_R;
`ifdef OBI_CMD_MGR_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT_R: begin
        if (obi_rsp_i.rvalid) begin
          rdata_d = we_q ? '0 : obi_rsp_i.r.rdata;
          err_d   = obi_rsp_i.r.err;
          state_d = RESP;
        end
`ifdef OBI_CMD_MGR_TIMEOUT_EN
        else if (cnt_q == CntWidth'(TimeoutCycles - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          stale_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
`endif
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef OBI_CMD_MGR_TIMEOUT_EN
    // A late rvalid belonging to a timed-out transaction is swallowed here
    if (stale_q && obi_rsp_i.rvalid) begin
      stale_d = 1'b0;
    end
`endif

    req_d       = (state_d == REQ);
    rsp_valid_d = (state_d == RESP);
`ifdef OBI_CMD_MGR_TIMEOUT_EN
    cmd_ready_d = (state_d == IDLE) && !stale_d;
`else
    cmd_ready_d = (state_d == IDLE);
`endif
  end

  // State, datapath and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      req_q       <= req_d;
    end
  end

`ifdef OBI_CMD_MGR_TIMEOUT_EN
  // Timeout counter and stale-response flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
    end
  end
`endif

  // Drive the OBI request straight from the registered A-channel fields
  always_comb begin
    obi_req_o         = '0;
    obi_req_o.req     = req_q;
    obi_req_o.a.addr  = addr_q;
    obi_req_o.a.we    = we_q;
    obi_req_o.a.be    = be_q;
    obi_req_o.a.wdata = wdata_q;
    obi_req_o.a.aid   = '0;
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_obi_cmd_manager.sv
// Directed self-checking bench for obi_cmd_manager; the subordinate is driven inline.
module tb_obi_cmd_manager;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_we;
  logic [3:0]  cmd_be;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  obi_pkg::obi_req_t obi_req;
  obi_pkg::obi_rsp_t obi_rsp;

  int checks = 0;
  int errors = 0;

  obi_cmd_manager #(
    .ObiCfg        (obi_pkg::ObiDefaultConfig),
    .obi_req_t     (obi_pkg::obi_req_t),
    .obi_rsp_t     (obi_pkg::obi_rsp_t),
    .TimeoutCycles (16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_addr_i  (cmd_addr),
    .cmd_we_i    (cmd_we),
    .cmd_be_i    (cmd_be),
    .cmd_wdata_i (cmd_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .obi_req_o   (obi_req),
    .obi_rsp_i   (obi_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_we = 1'b0; cmd_be = '0;
    cmd_wdata = '0; rsp_ready = 1'b0; obi_rsp = '0;
    tick; tick;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset rsp_valid: got %b want 0", rsp_valid); end
    checks++; if ({rsp_rdata, rsp_err} !== 33'h0) begin errors++; $display("FAIL reset rsp data/err: got %h/%b want 0/0", rsp_rdata, rsp_err); end
    checks++; if (obi_req !== '0) begin errors++; $display("FAIL reset obi_req: got %h want 0", obi_req); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_write;
    cmd_valid = 1'b1; cmd_addr = 32'h0300_0010; cmd_we = 1'b1; cmd_be = 4'hF; cmd_wdata = 32'hA5A5_0001;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL write cmd_ready c0: got %b want 1", cmd_ready); end
    tick;  // cycle 1
    cmd_valid = 1'b0;
    checks++;
    if ({obi_req.req, obi_req.a.addr, obi_req.a.we, obi_req.a.be, obi_req.a.wdata, obi_req.a.aid} !==
        {1'b1, 32'h0300_0010, 1'b1, 4'hF, 32'hA5A5_0001, 1'b0}) begin
      errors++; $display("FAIL write req c1: got req=%b addr=%h we=%b be=%h wdata=%h aid=%b",
                         obi_req.req, obi_req.a.addr, obi_req.a.we, obi_req.a.be, obi_req.a.wdata, obi_req.a.aid);
    end
    obi_rsp.gnt = 1'b1;
    tick;  // cycle 2
    obi_rsp.gnt = 1'b0;
    checks++; if (obi_req.req !== 1'b0) begin errors++; $display("FAIL write req c2: got %b want 0", obi_req.req); end
    obi_rsp.rvalid = 1'b1; obi_rsp.r.rdata = 32'hDEAD_BEEF; obi_rsp.r.err = 1'b0;
    tick;  // cycle 3
    obi_rsp.rvalid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL write rsp c3: got valid=%b rdata=%h err=%b want 1/0/0", rsp_valid, rsp_rdata, rsp_err);
    end
    rsp_ready = 1'b1;
    tick;  // cycle 4
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL write done c4: got rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_read_backpressure;
    cmd_valid = 1'b1; cmd_addr = 32'h0300_0020; cmd_we = 1'b0; cmd_be = 4'h3; cmd_wdata = 32'hFFFF_FFFF;
    tick;
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({obi_req.req, obi_req.a.addr, obi_req.a.we, obi_req.a.be, obi_req.a.wdata} !==
          {1'b1, 32'h0300_0020, 1'b0, 4'h3, 32'h0}) begin
        errors++; $display("FAIL rd req hold %0d: got req=%b addr=%h we=%b be=%h wdata=%h",
                           i, obi_req.req, obi_req.a.addr, obi_req.a.we, obi_req.a.be, obi_req.a.wdata);
      end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rd cmd_ready busy %0d: got %b want 0", i, cmd_ready); end
      // rvalid alongside gnt is illegal and must be ignored
      obi_rsp.gnt = (i == 3); obi_rsp.rvalid = (i == 3); obi_rsp.r.rdata = 32'h0000_0BAD;
      tick;
    end
    obi_rsp.gnt = 1'b0; obi_rsp.rvalid = 1'b0;
    checks++; if (obi_req.req !== 1'b0) begin errors++; $display("FAIL rd req after gnt: got %b want 0", obi_req.req); end
    tick;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd early rsp: got %b want 0", rsp_valid); end
    obi_rsp.rvalid = 1'b1; obi_rsp.r.rdata = 32'h1234_5678; obi_rsp.r.err = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      obi_rsp.rvalid = (i == 0); obi_rsp.r.rdata = 32'hFFFF_0000;
      checks++;
      if ({rsp_valid, rsp_rdata, rsp_err, cmd_ready} !== {1'b1, 32'h1234_5678, 1'b0, 1'b0}) begin
        errors++; $display("FAIL rd rsp hold %0d: got valid=%b rdata=%h err=%b cmd_ready=%b",
                           i, rsp_valid, rsp_rdata, rsp_err, cmd_ready);
      end
      tick;
    end
    obi_rsp.rvalid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rd rsp before ready: got %b want 1", rsp_valid); end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL rd done: got rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_error;
    cmd_valid = 1'b1; cmd_addr = 32'h0300_0030; cmd_we = 1'b0; cmd_be = 4'hF; cmd_wdata = 32'h0;
    tick;
    cmd_valid = 1'b0;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL err cmd_ready c1: got %b want 0", cmd_ready); end
    obi_rsp.gnt = 1'b1;
    tick;
    obi_rsp.gnt = 1'b0;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL err cmd_ready c2: got %b want 0", cmd_ready); end
    obi_rsp.rvalid = 1'b1; obi_rsp.r.rdata = 32'hBAD0_0000; obi_rsp.r.err = 1'b1;
    tick;
    obi_rsp.rvalid = 1'b0; obi_rsp.r.err = 1'b0;
    checks++;
    if ({rsp_valid, rsp_rdata, rsp_err, cmd_ready} !== {1'b1, 32'hBAD0_0000, 1'b1, 1'b0}) begin
      errors++; $display("FAIL err rsp: got valid=%b rdata=%h err=%b cmd_ready=%b want 1/bad00000/1/0",
                         rsp_valid, rsp_rdata, rsp_err, cmd_ready);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL err cmd_ready after rsp: got %b want 1", cmd_ready); end
    // gnt and rvalid in IDLE must not start or complete anything
    obi_rsp.gnt = 1'b1; obi_rsp.rvalid = 1'b1;
    tick;
    obi_rsp.gnt = 1'b0; obi_rsp.rvalid = 1'b0;
    checks++;
    if ({obi_req.req, rsp_valid, cmd_ready} !== 3'b001) begin
      errors++; $display("FAIL idle stray gnt/rvalid: got req=%b rsp_valid=%b cmd_ready=%b want 0/0/1",
                         obi_req.req, rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_back_to_back;
    int cmd_idx = 0;
    int rsp_cnt = 0;
    int issue_idx = 0;
    int rv_idx = 0;
    int last_cyc = 0;
    logic rv_pend = 1'b0;
    logic acc;
    logic [31:0] exp_rdata;
    cmd_valid = 1'b1; cmd_addr = 32'h0300_0100; cmd_we = 1'b0; cmd_be = 4'hF; cmd_wdata = 32'h5A00_0000;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && rsp_cnt < 8; cyc++) begin
      if (obi_req.req) begin
        checks++;
        if (obi_req.a.addr !== 32'h0300_0100 + 32'(4 * issue_idx)) begin
          errors++; $display("FAIL b2b addr %0d: got %h want %h", issue_idx, obi_req.a.addr, 32'h0300_0100 + 32'(4 * issue_idx));
        end
        issue_idx++;
      end
      if (rsp_valid) begin
        exp_rdata = (rsp_cnt % 2 == 1) ? 32'h0 : 32'hC0DE_0000 + 32'(rsp_cnt);
        checks++;
        if ({rsp_rdata, rsp_err} !== {exp_rdata, 1'b0}) begin
          errors++; $display("FAIL b2b rsp %0d: got rdata=%h err=%b want %h/0", rsp_cnt, rsp_rdata, rsp_err, exp_rdata);
        end
        if (rsp_cnt > 0) begin
          checks++;
          if (cyc - last_cyc != 4) begin
            errors++; $display("FAIL b2b spacing %0d: got %0d cycles want 4", rsp_cnt, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        rsp_cnt++;
      end
      acc = cmd_valid && cmd_ready;
      obi_rsp.gnt = obi_req.req;
      obi_rsp.rvalid = rv_pend;
      obi_rsp.r.err = 1'b0;
      if (rv_pend) begin
        obi_rsp.r.rdata = 32'hC0DE_0000 + 32'(rv_idx);
        rv_idx++;
      end
      rv_pend = obi_req.req;
      tick;
      if (acc) begin
        cmd_idx++;
        if (cmd_idx < 8) begin
          cmd_addr = 32'h0300_0100 + 32'(4 * cmd_idx);
          cmd_we = (cmd_idx % 2 == 1);
          cmd_wdata = 32'h5A00_0000 + 32'(cmd_idx);
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    obi_rsp = '0; rsp_ready = 1'b0; cmd_valid = 1'b0;
    checks++; if (rsp_cnt != 8) begin errors++; $display("FAIL b2b count: got %0d responses want 8", rsp_cnt); end
    tick;
  endtask

  task automatic test_reset_mid;
    cmd_valid = 1'b1; cmd_addr = 32'h0300_0040; cmd_we = 1'b0; cmd_be = 4'hF; cmd_wdata = 32'h0;
    tick;
    cmd_valid = 1'b0;
    obi_rsp.gnt = 1'b1;
    tick;  // now in WAIT_R
    obi_rsp.gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({obi_req.req, rsp_valid, cmd_ready} !== 3'b001) begin
      errors++; $display("FAIL midrst outputs: got req=%b rsp_valid=%b cmd_ready=%b want 0/0/1",
                         obi_req.req, rsp_valid, cmd_ready);
    end
    checks++; if (obi_req.a.addr !== 32'h0) begin errors++; $display("FAIL midrst a.addr: got %h want 0", obi_req.a.addr); end
    tick;
    rst_n = 1'b1;
    tick;
    cmd_valid = 1'b1; cmd_addr = 32'h0300_0050; cmd_we = 1'b1; cmd_be = 4'hC; cmd_wdata = 32'h0BAD_F00D;
    tick;
    cmd_valid = 1'b0;
    checks++;
    if ({obi_req.req, obi_req.a.addr, obi_req.a.we, obi_req.a.be, obi_req.a.wdata} !==
        {1'b1, 32'h0300_0050, 1'b1, 4'hC, 32'h0BAD_F00D}) begin
      errors++; $display("FAIL midrst next req: got req=%b addr=%h we=%b be=%h wdata=%h",
                         obi_req.req, obi_req.a.addr, obi_req.a.we, obi_req.a.be, obi_req.a.wdata);
    end
    obi_rsp.gnt = 1'b1;
    tick;
    obi_rsp.gnt = 1'b0; obi_rsp.rvalid = 1'b1; obi_rsp.r.rdata = 32'h1111_1111;
    tick;
    obi_rsp.rvalid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL midrst next rsp: got valid=%b rdata=%h err=%b want 1/0/0", rsp_valid, rsp_rdata, rsp_err);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

`ifdef OBI_CMD_MGR_TIMEOUT_EN
  task automatic test_timeout;
    cmd_valid = 1'b1; cmd_addr = 32'h0300_0070; cmd_we = 1'b0; cmd_be = 4'hF; cmd_wdata = 32'h0;
    tick;
    cmd_valid = 1'b0;
    obi_rsp.gnt = 1'b1;
    tick;
    obi_rsp.gnt = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL tmo early rsp at wait %0d: got %b want 0", i, rsp_valid); end
      tick;
    end
    checks++;
    if ({rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 32'h0, 1'b1}) begin
      errors++; $display("FAIL tmo rsp: got valid=%b rdata=%h err=%b want 1/0/1", rsp_valid, rsp_rdata, rsp_err);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 32'h0300_0060; cmd_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({cmd_ready, obi_req.req} !== 2'b00) begin
        errors++; $display("FAIL tmo stale stall %0d: got cmd_ready=%b req=%b want 0/0", i, cmd_ready, obi_req.req);
      end
      tick;
    end
    obi_rsp.rvalid = 1'b1; obi_rsp.r.rdata = 32'h5555_5555;
    tick;
    obi_rsp.rvalid = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL tmo late rvalid: got rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready);
    end
    tick;
    cmd_valid = 1'b0;
    checks++;
    if ({obi_req.req, obi_req.a.addr} !== {1'b1, 32'h0300_0060}) begin
      errors++; $display("FAIL tmo stalled cmd: got req=%b addr=%h want 1/03000060", obi_req.req, obi_req.a.addr);
    end
    obi_rsp.gnt = 1'b1;
    tick;
    obi_rsp.gnt = 1'b0; obi_rsp.rvalid = 1'b1; obi_rsp.r.rdata = 32'h7777_7777; obi_rsp.r.err = 1'b0;
    tick;
    obi_rsp.rvalid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 32'h7777_7777, 1'b0}) begin
      errors++; $display("FAIL tmo recovery rsp: got valid=%b rdata=%h err=%b want 1/77777777/0", rsp_valid, rsp_rdata, rsp_err);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_write;
    test_read_backpressure;
    test_error;
    test_back_to_back;
    test_reset_mid;
`ifdef OBI_CMD_MGR_TIMEOUT_EN
    test_timeout;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
